// File: rtl/vproc_bus_responder.sv
// Target-side responder for the VProc 32-bit word bus: local word memory, programmable wait
// states, one-cycle WRAck/RDAck pulses and a memory-mapped interrupt register.
module vproc_bus_responder #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] INT_ADDR    = 32'hFFFF_FFF0,
  parameter int unsigned INT_BITS    = 3
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [31:0]         addr_i,
  input  logic                we_i,
  input  logic                rd_i,
  input  logic [31:0]         wr_data_i,
  output logic [31:0]         rd_data_o,
  output logic                wr_ack_o,
  output logic                rd_ack_o,
  input  logic                burst_first_i,
  input  logic                burst_last_i,
  output logic [INT_BITS-1:0] interrupt_o,
  output logic                error_o,
  output logic [15:0]         burst_count_o
);

  localparam int unsigned Depth   = 2 ** ADDR_BITS;
  localparam logic [7:0]  WaitCnt = 8'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                write_q, write_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic                wr_ack_q, rd_ack_q;
  logic [31:0]         rd_data_q;
  logic [INT_BITS-1:0] int_q;
  logic [15:0]         burst_cnt_q;
  logic [31:0]         mem_q [Depth];

  // Access controls: sourced from live inputs for zero wait states, else from latched request.
  logic                acc_go, acc_write, acc_last, acc_int;
  logic [31:0]         acc_addr, acc_data;
  logic [ADDR_BITS-1:0] acc_idx;

  logic unused_burst_first;
  assign unused_burst_first = burst_first_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    write_d   = write_q;
    last_d    = last_q;
    err_d     = err_q;
    acc_go    = 1'b0;
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_data  = data_q;
    acc_last  = last_q;
    unique case (state_q)
      StIdle: begin
        if (we_i || rd_i) begin
          addr_d  = addr_i;
          data_d  = wr_data_i;
          write_d = we_i;
          last_d  = burst_last_i;
          cnt_d   = WaitCnt;
          if (we_i && rd_i) err_d = 1'b1;
          if (WaitCnt == 8'd0) begin
            acc_go    = 1'b1;
            acc_write = we_i;
            acc_addr  = addr_i;
            acc_data  = wr_data_i;
            acc_last  = burst_last_i;
            state_d   = StAck;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          acc_go  = 1'b1;
          state_d = StAck;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign acc_int = (acc_addr == INT_ADDR);
  assign acc_idx = acc_addr[ADDR_BITS-1:0];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      write_q     <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_data_q   <= 32'd0;
      int_q       <= '0;
      burst_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      write_q  <= write_d;
      last_q   <= last_d;
      err_q    <= err_d;
      wr_ack_q <= acc_go && acc_write;
      rd_ack_q <= acc_go && !acc_write;
      if (acc_go && acc_write && acc_int) int_q <= acc_data[INT_BITS-1:0];
      if (acc_go && !acc_write) rd_data_q <= acc_int ? 32'(int_q) : mem_q[acc_idx];
      if (acc_go && acc_last) burst_cnt_q <= burst_cnt_q + 16'd1;
    end
  end

  // Memory is deliberately left out of reset; a reset mid-access must not commit the write.
  always_ff @(posedge clk_i) begin
    if (!reset_i && acc_go && acc_write && !acc_int) mem_q[acc_idx] <= acc_data;
  end

  assign rd_data_o     = rd_data_q;
  assign wr_ack_o      = wr_ack_q;
  assign rd_ack_o      = rd_ack_q;
  assign interrupt_o   = int_q;
  assign error_o       = err_q;
  assign burst_count_o = burst_cnt_q;

endmodule
